multi_digit_timer: RTL and testbench
====================================

MULTI_DIGIT_TIMER -- requirements
Module: multi_digit_timer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of cascaded digits (1..8).
REQ-002 SHALL have parameter MOD, default 10, per-digit modulus (2..16); each digit counts 0..MOD-1.
REQ-003 SHALL have port Clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, reset; one clock, reset synchronous active-high.
REQ-005 SHALL have port set_time, input, 1, load Init_value and return to IDLE.
REQ-006 SHALL have ports start, pause and stop, input, 1 each, run, hold and terminate controls.
REQ-007 SHALL have port tick, input, 1, count-enable strobe; one step per high cycle.
REQ-008 SHALL have port UpOrDown, input, 1: 1 = up, 0 = down.
REQ-009 SHALL have port Init_value, input, 4*NUM_DIGITS, packed digits; digit 0 = bits [3:0] = least significant.
REQ-010 SHALL have port Count, output, 4*NUM_DIGITS, packed current digits.
REQ-011 SHALL have port carry, output, 1, one-cycle terminal-count pulse.
REQ-012 SHALL have ports busy, output, 1 (state==RUN), and done, output, 1 (state==DONE).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, STOP, DONE; all outputs registered.
REQ-014 SHALL apply per-cycle priority reset > set_time > stop > pause > start.
REQ-015 set_time SHALL load Init_value into Count, with any digit >= MOD clamped to MOD-1, and enter IDLE from any state.
REQ-016 IDLE: start=1 and pause=0 SHALL enter RUN next cycle; Count unchanged that cycle.
REQ-017 RUN: tick=1 SHALL step Count by one; tick=0 SHALL hold Count.
REQ-018 Up step SHALL increment digit 0; a digit at MOD-1 wraps to 0 and increments the next digit (ripple within the same cycle).
REQ-019 Down step SHALL decrement digit 0; a digit at 0 wraps to MOD-1 and decrements the next digit.
REQ-020 Terminal value SHALL be all digits MOD-1 when up, all digits 0 when down.
REQ-021 A step reaching terminal SHALL assert carry for exactly that next cycle.
REQ-022 If Count already equals terminal on entering RUN, SHALL enter DONE with carry pulse on the first tick.
REQ-023 RUN: pause=1 or start=0 SHALL enter PAUSE; Count frozen; a same-cycle tick is ignored.
REQ-024 PAUSE: pause=0 and start=1 SHALL return to RUN; counting resumes on the next tick.
REQ-025 stop=1 in RUN or PAUSE SHALL enter STOP, clear Count to 0 and carry to 0; exit only via set_time or reset.
REQ-026 DONE SHALL hold Count at terminal; start/pause/tick ignored; exit only via set_time or reset.
REQ-027 UpOrDown change in RUN SHALL take effect on the next tick without altering Count.

Reset
REQ-028 reset SHALL force state IDLE, Count=0, carry=0, busy=0 and done=0 at the next Clk edge, mid-count included.

Configuration
REQ-029 With AUTO_RELOAD_EN defined, a terminal step SHALL pulse carry, reload the clamped Init_value and stay in RUN instead of entering DONE.
REQ-030 Without AUTO_RELOAD_EN, DONE behaviour per REQ-026 SHALL apply, and no reload logic SHALL be present.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (3-bit) and the digit width constant (4).
REQ-032 Sub-module timer_digit SHALL provide one mod-MOD up/down digit: inputs en, dir, load, load_val; outputs value and wrap; instantiated NUM_DIGITS times via generate.

Verification (NUM_DIGITS=2, MOD=10)
REQ-033 Init 0x07, up, start, 3 ticks -> Count 0x08, 0x09, 0x10; no carry.
REQ-034 Init 0x98, up, run, 1 tick -> Count 0x99, carry one cycle, done=1; further ticks leave Count 0x99.
REQ-035 Init 0x01, down, 2 ticks -> 0x00 with carry; with AUTO_RELOAD_EN, the next tick reloads to 0x01 and busy stays 1.
REQ-036 Running at 0x45, pause and tick same cycle -> Count stays 0x45 in PAUSE; release pause with start=1, 1 tick -> 0x46.
REQ-037 Init 0xC3 -> Count 0x93 (clamp); stop in RUN -> Count 0x00 in STOP; start ignored until set_time.
REQ-038 reset mid-RUN at 0x57 -> next cycle Count 0x00, IDLE, busy=0, carry=0.

Source files
------------

// File: rtl/multi_digit_timer_pkg.sv
// Shared types and constants for the multi-digit timer.
package multi_digit_timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Out-of-range digits saturate at the top of the digit range.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                     input int modulus);
    logic [DIGIT_W-1:0] max_v;
    max_v = DIGIT_W'(modulus - 1);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/timer_digit.sv
// One mod-MOD up/down digit; wrap flags a carry/borrow into the next digit.
module timer_digit
  import multi_digit_timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

  logic [DIGIT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      if (dir) value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
      else     value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;
  assign wrap  = en && (dir ? (value_q == MAX_V) : (value_q == '0));

endmodule

// File: rtl/multi_digit_timer.sv
// Cascaded multi-digit up/down timer with run/pause/stop control.
// Optional AUTO_RELOAD_EN: terminal count reloads Init_value and keeps running.
module multi_digit_timer
  import multi_digit_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MOD        = 10
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          set_time,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          stop,
  input  logic                          tick,
  input  logic                          UpOrDown,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] Init_value,
  output logic [DIGIT_W*NUM_DIGITS-1:0] Count,
  output logic                          carry,
  output logic                          busy,
  output logic                          done
);

  localparam logic [DIGIT_W-1:0] MAX_V  = DIGIT_W'(MOD - 1);
  localparam logic [DIGIT_W-1:0] PRE_UP = DIGIT_W'(MOD - 2);

  state_e state_q, state_d;
  logic   carry_q, carry_d;
  logic   step, load_en, clear;

  logic [DIGIT_W-1:0]    digit_val  [NUM_DIGITS];
  logic [DIGIT_W-1:0]    load_val   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_en;
  logic [NUM_DIGITS-1:0] digit_wrap;
  logic [NUM_DIGITS-1:0] term_match;
  logic [NUM_DIGITS-1:0] pre_match;
  logic                  at_term, pre_term;
  logic                  unused_top_wrap;

  logic [DIGIT_W-1:0] term_digit, pre_digit;
  assign term_digit = UpOrDown ? MAX_V : '0;
  assign pre_digit  = UpOrDown ? PRE_UP : DIGIT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign load_val[gi] = clear ? '0
                                  : clamp_digit(Init_value[gi*DIGIT_W +: DIGIT_W], MOD);
      if (gi == 0) begin : g_lsd
        assign digit_en[gi]  = step;
        assign pre_match[gi] = (digit_val[gi] == pre_digit);
      end else begin : g_upper
        // Ripple: a digit steps only when every lower digit wraps this cycle.
        assign digit_en[gi]  = digit_wrap[gi-1];
        assign pre_match[gi] = term_match[gi];
      end
      assign term_match[gi] = (digit_val[gi] == term_digit);
      assign Count[gi*DIGIT_W +: DIGIT_W] = digit_val[gi];

      timer_digit #(.MOD(MOD)) u_digit (
        .clk      (Clk),
        .srst     (reset),
        .en       (digit_en[gi]),
        .dir      (UpOrDown),
        .load     (load_en),
        .load_val (load_val[gi]),
        .value    (digit_val[gi]),
        .wrap     (digit_wrap[gi])
      );
    end
  endgenerate

  // The counter never steps from terminal, so the top digit's wrap is unused.
  assign unused_top_wrap = digit_wrap[NUM_DIGITS-1];
  assign at_term  = &term_match;
  assign pre_term = &pre_match;

  always_comb begin
    state_d = state_q;
    carry_d = 1'b0;
    step    = 1'b0;
    load_en = 1'b0;
    clear   = 1'b0;
    if (set_time) begin
      state_d = ST_IDLE;
      load_en = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && !pause && start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_STOP;
            load_en = 1'b1;
            clear   = 1'b1;
          end else if (pause || !start) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (at_term) begin
`ifdef AUTO_RELOAD_EN
              load_en = 1'b1;
`else
              state_d = ST_DONE;
              carry_d = 1'b1;
`endif
            end else begin
              step = 1'b1;
              if (pre_term) begin
                carry_d = 1'b1;
`ifndef AUTO_RELOAD_EN
                state_d = ST_DONE;
`endif
              end
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_d = ST_STOP;
            load_en = 1'b1;
            clear   = 1'b1;
          end else if (!pause && start) begin
            state_d = ST_RUN;
          end
        end
        ST_STOP, ST_DONE: begin
          state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_multi_digit_timer.sv
// Scoreboard bench for multi_digit_timer (NUM_DIGITS=2, MOD=10).
module tb_multi_digit_timer;

`ifdef AUTO_RELOAD_EN
  localparam logic AR = 1'b1;
`else
  localparam logic AR = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset, set_time, start, pause, stop, tick, UpOrDown;
  logic [7:0] Init_value;
  logic [7:0] Count;
  logic       carry, busy, done;

  multi_digit_timer #(.NUM_DIGITS(2), .MOD(10)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .set_time   (set_time),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .tick       (tick),
    .UpOrDown   (UpOrDown),
    .Init_value (Init_value),
    .Count      (Count),
    .carry      (carry),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [7:0] count;
    logic       cy;
    logic       bz;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every queued expectation describes the state just after the next edge.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({Count, carry, busy, done} !== {e.count, e.cy, e.bz, e.dn}) begin
        n_fail++;
        $display("[TB] FAIL %s: got count=%h carry=%b busy=%b done=%b, expected count=%h carry=%b busy=%b done=%b",
                 e.name, Count, carry, busy, done, e.count, e.cy, e.bz, e.dn);
      end else begin
        $display("[TB] %s count=%h carry=%b busy=%b done=%b ok", e.name, Count, carry, busy, done);
      end
    end
  end

  task automatic cyc(input string name, input logic rst, input logic st, input logic sa,
                     input logic pa, input logic sp, input logic tk, input logic ud,
                     input logic [7:0] iv, input logic [7:0] ec, input logic ecy,
                     input logic eb, input logic ed);
    reset      = rst;
    set_time   = st;
    start      = sa;
    pause      = pa;
    stop       = sp;
    tick       = tk;
    UpOrDown   = ud;
    Init_value = iv;
    exp_q.push_back('{name, ec, ecy, eb, ed});
    @(negedge Clk);
  endtask

  initial begin
    //   name            rst set sta pau stp tk ud init   count  cy  busy done
    cyc("reset",          1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    // up count with decimal ripple
    cyc("load07",         0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h07, 0, 0, 0);
    cyc("run07",          0, 0, 1, 0, 0, 0, 1, 8'h07, 8'h07, 0, 1, 0);
    cyc("up08",           0, 0, 1, 0, 0, 1, 1, 8'h07, 8'h08, 0, 1, 0);
    cyc("up09",           0, 0, 1, 0, 0, 1, 1, 8'h07, 8'h09, 0, 1, 0);
    cyc("up10",           0, 0, 1, 0, 0, 1, 1, 8'h07, 8'h10, 0, 1, 0);
    cyc("hold10_notick",  0, 0, 1, 0, 0, 0, 1, 8'h07, 8'h10, 0, 1, 0);
    // up terminal
    cyc("load98",         0, 1, 0, 0, 0, 0, 1, 8'h98, 8'h98, 0, 0, 0);
    cyc("run98",          0, 0, 1, 0, 0, 0, 1, 8'h98, 8'h98, 0, 1, 0);
    cyc("up99_term",      0, 0, 1, 0, 0, 1, 1, 8'h98, 8'h99, 1, AR, !AR);
    cyc("after99",        0, 0, 1, 0, 0, 1, 1, 8'h98, AR ? 8'h98 : 8'h99, 0, AR, !AR);
    // down terminal
    cyc("load01",         0, 1, 0, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0, 0);
    cyc("run01",          0, 0, 1, 0, 0, 0, 0, 8'h01, 8'h01, 0, 1, 0);
    cyc("dn00_term",      0, 0, 1, 0, 0, 1, 0, 8'h01, 8'h00, 1, AR, !AR);
    cyc("after00",        0, 0, 1, 0, 0, 1, 0, 8'h01, AR ? 8'h01 : 8'h00, 0, AR, !AR);
    // already at terminal when entering RUN
    cyc("load99",         0, 1, 0, 0, 0, 0, 1, 8'h99, 8'h99, 0, 0, 0);
    cyc("run99",          0, 0, 1, 0, 0, 0, 1, 8'h99, 8'h99, 0, 1, 0);
    cyc("tick_at_term",   0, 0, 1, 0, 0, 1, 1, 8'h99, 8'h99, !AR, AR, !AR);
    // direction change mid-run, down ripple across digits
    cyc("load10",         0, 1, 0, 0, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0);
    cyc("run10",          0, 0, 1, 0, 0, 0, 1, 8'h10, 8'h10, 0, 1, 0);
    cyc("up11",           0, 0, 1, 0, 0, 1, 1, 8'h10, 8'h11, 0, 1, 0);
    cyc("dir_dn10",       0, 0, 1, 0, 0, 1, 0, 8'h10, 8'h10, 0, 1, 0);
    cyc("dn09",           0, 0, 1, 0, 0, 1, 0, 8'h10, 8'h09, 0, 1, 0);
    // pause / resume
    cyc("load45",         0, 1, 0, 0, 0, 0, 1, 8'h45, 8'h45, 0, 0, 0);
    cyc("run45",          0, 0, 1, 0, 0, 0, 1, 8'h45, 8'h45, 0, 1, 0);
    cyc("pause_tick45",   0, 0, 1, 1, 0, 1, 1, 8'h45, 8'h45, 0, 0, 0);
    cyc("paused_tick45",  0, 0, 1, 1, 0, 1, 1, 8'h45, 8'h45, 0, 0, 0);
    cyc("resume45",       0, 0, 1, 0, 0, 0, 1, 8'h45, 8'h45, 0, 1, 0);
    cyc("up46",           0, 0, 1, 0, 0, 1, 1, 8'h45, 8'h46, 0, 1, 0);
    cyc("start_low46",    0, 0, 0, 0, 0, 1, 1, 8'h45, 8'h46, 0, 0, 0);
    cyc("stop_in_pause",  0, 0, 0, 0, 1, 0, 1, 8'h45, 8'h00, 0, 0, 0);
    // clamp and stop in RUN
    cyc("loadC3_clamp",   0, 1, 0, 0, 0, 0, 1, 8'hC3, 8'h93, 0, 0, 0);
    cyc("run93",          0, 0, 1, 0, 0, 0, 1, 8'hC3, 8'h93, 0, 1, 0);
    cyc("up94",           0, 0, 1, 0, 0, 1, 1, 8'hC3, 8'h94, 0, 1, 0);
    cyc("stop_in_run",    0, 0, 1, 0, 1, 1, 1, 8'hC3, 8'h00, 0, 0, 0);
    cyc("start_in_stop",  0, 0, 1, 0, 0, 1, 1, 8'hC3, 8'h00, 0, 0, 0);
    cyc("load3F_clamp",   0, 1, 0, 0, 0, 0, 1, 8'h3F, 8'h39, 0, 0, 0);
    // down ripple from 20
    cyc("load20",         0, 1, 0, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0);
    cyc("run20",          0, 0, 1, 0, 0, 0, 0, 8'h20, 8'h20, 0, 1, 0);
    cyc("dn19",           0, 0, 1, 0, 0, 1, 0, 8'h20, 8'h19, 0, 1, 0);
    // reset mid-run
    cyc("load56",         0, 1, 0, 0, 0, 0, 1, 8'h56, 8'h56, 0, 0, 0);
    cyc("run56",          0, 0, 1, 0, 0, 0, 1, 8'h56, 8'h56, 0, 1, 0);
    cyc("up57",           0, 0, 1, 0, 0, 1, 1, 8'h56, 8'h57, 0, 1, 0);
    cyc("reset_mid_run",  1, 0, 1, 0, 0, 1, 1, 8'h56, 8'h00, 0, 0, 0);
    cyc("start_after_rst",0, 0, 1, 0, 0, 1, 1, 8'h56, 8'h00, 0, 1, 0);

    repeat (2) @(negedge Clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
